onebit_array_responder: RTL and testbench
=========================================

# onebit_array_responder

Array-side responder for the one-bit SRAM control interface: consumes the precharge/wordline/sense-amp/write strobes driven by the control generator and behaves as the bitcell column plus sense amplifier. It holds a small word array, performs writes and registered reads, tracks bitline precharge state, and flags protocol violations. It sits below the generator in the macro hierarchy and serves as both a synthesizable behavioural array and a protocol checker for simulation.

## Interface
- DEPTH, 16: number of words; power of two, ≥2.
- WIDTH, 1: bits per word.
- AW, $clog2(DEPTH): address width.
- clk  in  1  clock; all sampling on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- preb  in  1  precharge, active-low (0 = bitlines charging).
- sampleb  in  1  wordline enable, active-low; must equal ~WL.
- sa_en  in  1  sense-amp enable (read strobe).
- write_bit  in  1  write strobe.
- WL  in  1  wordline.
- WLB  in  1  complementary wordline; must be 0 whenever WL=1.
- addr  in  AW  word address, sampled in access cycles.
- din  in  WIDTH  write data, sampled in write cycles.
- err_clr  in  1  clears sticky error flags.
- dout  out  WIDTH  read data; holds last value between reads.
- dout_valid  out  1  one-cycle pulse, read data valid.
- err_noprech  out  1  sticky: access without prior precharge.
- err_illegal  out  1  sticky: illegal strobe combination.
- rd_cnt  out  16  saturating count of completed reads.
- wr_cnt  out  16  saturating count of completed writes.

## Operation
- Each cycle the strobes are decoded into one class:
  - PRE: preb=0, WL=0, sampleb=1, sa_en=0, write_bit=0.
  - WRITE: preb=1, WL=1, sampleb=0, WLB=0, write_bit=1, sa_en=0.
  - READ: preb=1, WL=1, sampleb=0, WLB=0, sa_en=1, write_bit=0.
  - IDLE: preb=1, WL=0, sampleb=1, sa_en=0, write_bit=0.
  - ILLEGAL: anything else, including WL=1 with preb=0, sa_en=1 with write_bit=1, WL=WLB=1, and sampleb==WL.
- Bitline state machine, 2 states:
  - CHARGED: entered on PRE from any state.
  - SPENT: the reset state; entered on READ or WRITE.
  - IDLE holds the state. ILLEGAL forces SPENT.
- WRITE: mem[addr] <= din. wr_cnt increments.
- READ: dout <= mem[addr] and dout_valid pulses. rd_cnt increments.
- READ or WRITE while SPENT: the operation is still performed and err_noprech is set. Back-to-back accesses without precharge are therefore functional but flagged.
- ILLEGAL: no memory update, no dout_valid, no counter change; err_illegal is set.
- Counters saturate at 16'hFFFF.
- err_clr: clears both flags at the edge. A new error in the same cycle wins, so the flag stays 1.

## Timing
- Reset (rst_n=0 at an edge):
  - dout=0, dout_valid=0, both err flags 0, both counters 0, bitline state SPENT.
  - Memory contents are not cleared.
  - Any access presented in a reset cycle is ignored.
- Write latency 0: memory is updated at the sampling edge.
- Read latency 1: strobes sampled at edge N, so dout/dout_valid are visible after edge N.
- A read in cycle N+1 of an address written in cycle N returns the new data.
- Consecutive READ cycles produce consecutive dout_valid pulses, one per read.
- Error flags assert in the cycle after the offending sample.
- Address wrap: addr is AW bits wide, so no out-of-range access is possible.

## Structure
- Shared package onebit_pkg:
  - strobe-class enum {PRE, IDLE, READ, WRITE, ILLEGAL};
  - bitline-state enum {CHARGED, SPENT};
  - counter width constant CNT_W=16.
- One sub-module, onebit_strobe_decode: combinational classifier from the six strobes to the class enum. It is shared with the generator's own assertions.
- Memory is a plain register array inferred in the top module.

## Test plan
- Reset then PRE, WRITE addr=3 din=1, PRE, READ addr=3 -> dout=1 with dout_valid one cycle after READ; wr_cnt=1, rd_cnt=1, no error flags.
- After reset, READ with no preceding PRE -> read still completes, err_noprech=1; err_clr=1 next cycle -> flag 0.
- Continuous WRITE, WRITE, READ to the same address with no PRE (the generator's steady-state pattern) -> data correct, err_noprech=1, rd_cnt=1, wr_cnt=2.
- sa_en=1 and write_bit=1 together in one cycle -> err_illegal=1, memory unchanged, no dout_valid, counters unchanged.
- rst_n=0 during a READ cycle -> no dout_valid, counters 0, memory contents written before reset still readable afterwards.
- Force rd_cnt near 16'hFFFF and issue 3 more reads -> rd_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/onebit_pkg.sv
// Shared types for the one-bit SRAM control interface: strobe classes, bitline state and
// counter width.
package onebit_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {PRE, IDLE, READ, WRITE, ILLEGAL} strobe_cls_e;

   typedef enum logic {CHARGED, SPENT} bl_state_e;

endpackage

// File: rtl/onebit_strobe_decode.sv
// Combinational classifier turning the six array strobes into one strobe class per cycle.
module onebit_strobe_decode
   import onebit_pkg::*;
(
   input  logic        preb,
   input  logic        sampleb,
   input  logic        sa_en,
   input  logic        write_bit,
   input  logic        WL,
   input  logic        WLB,
   output strobe_cls_e cls
);

   // WLB only matters while the wordline is up; PRE and IDLE ignore it.
   always_comb begin
      cls = ILLEGAL;
      if (!preb && !WL && sampleb && !sa_en && !write_bit) begin
         cls = PRE;
      end else if (preb && !WL && sampleb && !sa_en && !write_bit) begin
         cls = IDLE;
      end else if (preb && WL && !sampleb && !WLB && !sa_en && write_bit) begin
         cls = WRITE;
      end else if (preb && WL && !sampleb && !WLB && sa_en && !write_bit) begin
         cls = READ;
      end
   end

endmodule

// File: rtl/onebit_array_responder.sv
// Behavioural bitcell array plus sense amp: writes, registered reads, bitline precharge
// tracking and sticky protocol-violation flags.
module onebit_array_responder
   import onebit_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 1,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             preb,
   input  logic             sampleb,
   input  logic             sa_en,
   input  logic             write_bit,
   input  logic             WL,
   input  logic             WLB,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   input  logic             err_clr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic             err_noprech,
   output logic             err_illegal,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
);

   strobe_cls_e      cls;
   bl_state_e        bl_state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             access;

   onebit_strobe_decode u_decode (
      .preb      (preb),
      .sampleb   (sampleb),
      .sa_en     (sa_en),
      .write_bit (write_bit),
      .WL        (WL),
      .WLB       (WLB),
      .cls       (cls)
   );

   assign access = (cls == READ) || (cls == WRITE);

   // Array contents survive reset; only the write itself is suppressed in a reset cycle.
   always_ff @(posedge clk) begin
      if (rst_n && cls == WRITE) begin
         mem[addr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bl_state    <= SPENT;
         dout        <= '0;
         dout_valid  <= 1'b0;
         err_noprech <= 1'b0;
         err_illegal <= 1'b0;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
      end else begin
         dout_valid <= 1'b0;
         unique case (cls)
            PRE:     bl_state <= CHARGED;
            IDLE:    bl_state <= bl_state;
            READ: begin
               bl_state   <= SPENT;
               dout       <= mem[addr];
               dout_valid <= 1'b1;
               if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            end
            WRITE: begin
               bl_state <= SPENT;
               if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            end
            default: bl_state <= SPENT;
         endcase

         // A fresh violation outranks a simultaneous clear.
         if (access && bl_state == SPENT) begin
            err_noprech <= 1'b1;
         end else if (err_clr) begin
            err_noprech <= 1'b0;
         end
         if (cls == ILLEGAL) begin
            err_illegal <= 1'b1;
         end else if (err_clr) begin
            err_illegal <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_onebit_array_responder.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized phase
// checked every cycle against a behavioural array model.
module tb_onebit_array_responder;

   logic        clk = 1'b0;
   logic        rst_n, preb, sampleb, sa_en, write_bit, WL, WLB, err_clr;
   logic [3:0]  addr;
   logic [0:0]  din;
   logic [0:0]  dout;
   logic        dout_valid, err_noprech, err_illegal;
   logic [15:0] rd_cnt, wr_cnt;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   bit          m_dout, m_valid, m_noprech, m_illegal, m_charged;
   int unsigned m_rd, m_wr;
   bit          m_mem [16];

   always #5 clk = ~clk;

   onebit_array_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .preb        (preb),
      .sampleb     (sampleb),
      .sa_en       (sa_en),
      .write_bit   (write_bit),
      .WL          (WL),
      .WLB         (WLB),
      .addr        (addr),
      .din         (din),
      .err_clr     (err_clr),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .err_noprech (err_noprech),
      .err_illegal (err_illegal),
      .rd_cnt      (rd_cnt),
      .wr_cnt      (wr_cnt)
   );

   // 0 PRE, 1 IDLE, 2 READ, 3 WRITE, 4 ILLEGAL; bit order {preb,WL,sampleb,sa_en,write_bit,WLB}
   function automatic int classify(input logic [5:0] v);
      casez (v)
         6'b00100?: return 0;
         6'b10100?: return 1;
         6'b110100: return 2;
         6'b110010: return 3;
         default:   return 4;
      endcase
   endfunction

   always @(posedge clk) begin : model
      int  c;
      bit  np_set, il_set;
      if (!rst_n) begin
         m_dout = 0; m_valid = 0; m_noprech = 0; m_illegal = 0; m_charged = 0;
         m_rd = 0; m_wr = 0;
      end else begin
         c = classify({preb, WL, sampleb, sa_en, write_bit, WLB});
         np_set  = (c == 2 || c == 3) && !m_charged;
         il_set  = (c == 4);
         m_valid = 0;
         if (c == 0) m_charged = 1;
         if (c == 2) begin
            m_dout  = m_mem[addr];
            m_valid = 1;
            m_rd    = (m_rd >= 65535) ? 65535 : m_rd + 1;
         end
         if (c == 3) begin
            m_mem[addr] = din[0];
            m_wr = (m_wr >= 65535) ? 65535 : m_wr + 1;
         end
         if (c >= 2) m_charged = 0;
         m_noprech = np_set ? 1'b1 : (err_clr ? 1'b0 : m_noprech);
         m_illegal = il_set ? 1'b1 : (err_clr ? 1'b0 : m_illegal);
      end
   end

   task automatic check(input string nm, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("dout", {31'b0, dout}, {31'b0, m_dout});
         check("dout_valid", {31'b0, dout_valid}, {31'b0, m_valid});
         check("err_noprech", {31'b0, err_noprech}, {31'b0, m_noprech});
         check("err_illegal", {31'b0, err_illegal}, {31'b0, m_illegal});
         check("rd_cnt", {16'b0, rd_cnt}, m_rd);
         check("wr_cnt", {16'b0, wr_cnt}, m_wr);
      end
   end

   task automatic drv(input bit p, input bit s, input bit sa, input bit wb, input bit wl,
                      input bit wlb, input int a, input bit d, input bit clr);
      preb = p; sampleb = s; sa_en = sa; write_bit = wb; WL = wl; WLB = wlb;
      addr = a[3:0]; din = d; err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic t_pre();             drv(0, 1, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic t_idle();            drv(1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic t_clr();             drv(1, 1, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic t_rd(input int a);   drv(1, 0, 1, 0, 1, 0, a, 0, 0); endtask
   task automatic t_wr(input int a, input bit d); drv(1, 0, 0, 1, 1, 0, a, d, 0); endtask
   task automatic t_rst();
      rst_n = 0;
      t_idle();
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0;
      t_idle();
      chk_en = 1'b1;
      rst_n = 1;
      check("reset dout", {31'b0, dout}, 0);
      check("reset dout_valid", {31'b0, dout_valid}, 0);
      check("reset errs", {30'b0, err_noprech, err_illegal}, 0);
      check("reset counters", {rd_cnt, wr_cnt}, 0);

      for (int i = 0; i < 16; i++) t_wr(i, 1'b0);
      t_rst();

      // Precharged write then read
      t_pre(); t_wr(3, 1); t_pre(); t_rd(3);
      check("t1 dout", {31'b0, dout}, 1);
      check("t1 valid", {31'b0, dout_valid}, 1);
      check("t1 counts", {rd_cnt, wr_cnt}, 32'h0001_0001);
      check("t1 errs", {30'b0, err_noprech, err_illegal}, 0);
      t_idle();
      check("t1 valid pulse", {31'b0, dout_valid}, 0);

      // Read straight after reset, no precharge
      t_rst(); t_rd(3);
      check("t2 valid", {31'b0, dout_valid}, 1);
      check("t2 noprech", {31'b0, err_noprech}, 1);
      t_clr();
      check("t2 cleared", {31'b0, err_noprech}, 0);

      // Steady-state write/write/read without precharge
      t_rst(); t_wr(5, 0); t_wr(5, 1); t_rd(5);
      check("t3 dout", {31'b0, dout}, 1);
      check("t3 noprech", {31'b0, err_noprech}, 1);
      check("t3 counts", {rd_cnt, wr_cnt}, 32'h0001_0002);

      // sa_en and write_bit together
      t_rst(); t_pre(); drv(1, 0, 1, 1, 1, 0, 3, 0, 0);
      check("t4 illegal", {31'b0, err_illegal}, 1);
      check("t4 valid", {31'b0, dout_valid}, 0);
      check("t4 counts", {rd_cnt, wr_cnt}, 0);
      t_pre(); t_rd(3);
      check("t4 mem kept", {31'b0, dout}, 1);

      // Reset asserted during a read
      t_rst(); t_pre(); t_wr(7, 1);
      rst_n = 0; t_rd(7); rst_n = 1;
      check("t5 valid", {31'b0, dout_valid}, 0);
      check("t5 counts", {rd_cnt, wr_cnt}, 0);
      t_pre(); t_rd(7);
      check("t5 mem kept", {31'b0, dout}, 1);

      // Read counter saturation
      t_rst();
      for (int i = 0; i < 65534; i++) t_rd(i % 16);
      check("t6 near sat", {16'b0, rd_cnt}, 32'hFFFE);
      for (int i = 0; i < 3; i++) t_rd(i);
      check("t6 saturated", {16'b0, rd_cnt}, 32'hFFFF);
      check("t6 wr untouched", {16'b0, wr_cnt}, 0);

      // Randomized traffic
      t_rst();
      for (int n = 0; n < 3000; n++) begin
         int op;
         rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         op = $urandom_range(0, 9);
         if (op < 2) begin
            preb = 0; sampleb = 1; sa_en = 0; write_bit = 0; WL = 0; WLB = $urandom_range(0, 1);
         end else if (op < 4) begin
            preb = 1; sampleb = 0; sa_en = 0; write_bit = 1; WL = 1; WLB = 0;
         end else if (op < 7) begin
            preb = 1; sampleb = 0; sa_en = 1; write_bit = 0; WL = 1; WLB = 0;
         end else if (op == 7) begin
            preb = 1; sampleb = 1; sa_en = 0; write_bit = 0; WL = 0; WLB = $urandom_range(0, 1);
         end else begin
            {preb, sampleb, sa_en, write_bit, WL, WLB} = 6'($urandom_range(0, 63));
         end
         addr = 4'($urandom_range(0, 15));
         din = 1'($urandom_range(0, 1));
         err_clr = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         #1;
      end
      rst_n = 1;
      t_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
